// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter for the serial shift link.
// Latency: the first bit is on ser_out one clk after accept; a word takes WIDTH enabled clks.
// Backpressure: load_ready is low while a word is in flight, except during its last enabled bit.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;   // word being sent; the bit on the line sits at the send end
  logic [CW-1:0]    cnt;     // bits still to send after the one on the line
  logic             at_last;
  logic             accept;

  // The last bit is on the line once the countdown has reached zero.
  assign at_last = (state == SHIFT) && (cnt == '0);

  // A new word may enter when idle, or on the enabled clk that retires the last bit,
  // which is what lets back-to-back words stream with no gap.
  assign load_ready = (state == IDLE) || (at_last && shift_en);
  assign accept     = load_valid && load_ready;

  assign ser_last = at_last;
  assign busy     = (state == SHIFT);

  // Control FSM, shift register and registered serial outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else if (accept) begin
      // Capture the word; its first bit goes straight onto the line.
      state     <= SHIFT;
      shreg     <= load_data;
      cnt       <= CW'(WIDTH - 1);
      ser_out   <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      ser_valid <= 1'b1;
    end else if ((state == SHIFT) && shift_en) begin
      if (cnt == '0) begin
        // Last bit retired with nothing waiting: drop back to idle.
        state     <= IDLE;
        shreg     <= '0;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        if (MSB_FIRST) begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          ser_out <= shreg[WIDTH-2];
        end else begin
          shreg   <= {1'b0, shreg[WIDTH-1:1]};
          ser_out <= shreg[1];
        end
      end
    end
  end

endmodule
